// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a fall-through FIFO and packs LANES consecutive
// DSIZE-bit words into one wide output word with a lane-enable mask.
// A flush request emits a partially filled word; a one-deep output register
// with valid/ready handshake decouples the packer from the consumer.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int LANES = 4
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [DSIZE-1:0]       fifo_rdata,
    input  logic                   fifo_rempty,
    output logic                   fifo_rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_be,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            words_out
);

    localparam int LW = $clog2(LANES);
    localparam int WW = DSIZE * LANES;

    // FILL: accepting FIFO words. HOLD: full word waiting for the output slot.
    // FLUSH: partial word waiting for the output slot.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [WW-1:0]    asm_q, asm_d;
    logic [WW-1:0]    odata_q, odata_d;
    logic [LANES-1:0] obe_q, obe_d;
    logic             ovld_q, ovld_d;
    logic [15:0]      words_q, words_d;

    logic             slot_free;
    logic             cap;
    logic             word_done;
    logic [LW-1:0]    lane_nxt;
    logic [WW-1:0]    asm_cap;
    logic             load;
    logic [WW-1:0]    ld_data;
    logic [LANES-1:0] ld_be;

    // Lanes [cnt-1:0] enabled for a partial word holding cnt entries.
    function automatic logic [LANES-1:0] be_mask(input logic [LW-1:0] cnt);
        logic [LANES-1:0] m;
        m = '0;
        for (int k = 0; k < LANES; k++) begin
            m[k] = (k < int'(cnt));
        end
        return m;
    endfunction

    // Read request: only while accepting, and never while held in reset.
    always_comb begin
        fifo_rinc = rrst_n & ~fifo_rempty & (state_q == FILL);
    end

    // Capture bookkeeping: the assembly word and lane count as they would be
    // after this cycle's capture, so flush sees the post-capture count.
    always_comb begin
        cap       = fifo_rinc;
        slot_free = ~ovld_q | out_ready;
        word_done = cap && (lane_q == LW'(LANES - 1));
        lane_nxt  = cap ? lane_q + LW'(1) : lane_q;
        asm_cap   = asm_q;
        for (int k = 0; k < LANES; k++) begin
            if (cap && (lane_q == LW'(k))) begin
                asm_cap[k*DSIZE +: DSIZE] = fifo_rdata;
            end
        end
    end

    // Next-state logic: decides when the assembly word moves to the output.
    // The assembly register is cleared on every emit so unfilled lanes of a
    // later partial word read back as zero.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_nxt;
        asm_d   = asm_cap;
        load    = 1'b0;
        ld_data = asm_cap;
        ld_be   = '0;
        case (state_q)
            FILL: begin
                if (word_done) begin
                    lane_d = '0;
                    if (slot_free) begin
                        load    = 1'b1;
                        ld_data = asm_cap;
                        ld_be   = '1;
                        asm_d   = '0;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (flush && (lane_nxt != '0)) begin
                    if (slot_free) begin
                        load    = 1'b1;
                        ld_data = asm_cap;
                        ld_be   = be_mask(lane_nxt);
                        asm_d   = '0;
                        lane_d  = '0;
                    end else begin
                        // Keep the count: it sizes the mask when we emit.
                        state_d = FLUSH;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load    = 1'b1;
                    ld_data = asm_q;
                    ld_be   = '1;
                    asm_d   = '0;
                    lane_d  = '0;
                    state_d = FILL;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load    = 1'b1;
                    ld_data = asm_q;
                    ld_be   = be_mask(lane_q);
                    asm_d   = '0;
                    lane_d  = '0;
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                lane_d  = '0;
                asm_d   = '0;
            end
        endcase
    end

    // Output slot: reload on emit, otherwise drop valid once accepted;
    // data and mask are untouched while a word waits.
    always_comb begin
        odata_d = odata_q;
        obe_d   = obe_q;
        ovld_d  = ovld_q;
        words_d = words_q;
        if (ovld_q && out_ready) begin
            ovld_d  = 1'b0;
            words_d = words_q + 16'd1;
        end
        if (load) begin
            odata_d = ld_data;
            obe_d   = ld_be;
            ovld_d  = 1'b1;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= FILL;
            lane_q  <= '0;
            asm_q   <= '0;
            odata_q <= '0;
            obe_q   <= '0;
            ovld_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            odata_q <= odata_d;
            obe_q   <= obe_d;
            ovld_q  <= ovld_d;
            words_q <= words_d;
        end
    end

    // Output port drive.
    always_comb begin
        out_data  = odata_q;
        out_be    = obe_q;
        out_valid = ovld_q;
        words_out = words_q;
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small fall-through FIFO model feeds
// bytes, a negedge monitor records accepted words and read pulses.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [7:0]  fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] words_out;

    int n_chk = 0;
    int n_fail = 0;

    fifo_rd_packer #(.DSIZE(8), .LANES(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
        .flush(flush),
        .out_data(out_data), .out_be(out_be), .out_valid(out_valid),
        .out_ready(out_ready), .words_out(words_out)
    );

    always #5 rclk = ~rclk;

    // FIFO model
    logic [7:0] mem [0:1023];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    logic empty_force = 1'b0;
    assign fifo_rempty = (rd_ptr == wr_ptr) || empty_force;
    assign fifo_rdata  = mem[rd_ptr[9:0]];
    always @(posedge rclk) if (fifo_rinc) rd_ptr <= rd_ptr + 1;

    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    // Monitor
    logic [31:0] obs_d[$];
    logic [3:0]  obs_b[$];
    int          rinc_cyc[$];
    int          viol = 0;
    always @(negedge rclk) begin
        if (fifo_rinc && (fifo_rempty || !rrst_n)) viol++;
        if (rrst_n) begin
            if (fifo_rinc) rinc_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_b.push_back(out_be);
            end
        end
    end

    task automatic clear_obs();
        obs_d.delete(); obs_b.delete(); rinc_cyc.delete(); viol = 0;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[9:0]] = b;
        wr_ptr++;
    endtask

    task automatic apply_reset();
        rrst_n = 1'b0; flush = 1'b0; empty_force = 1'b0; out_ready = 1'b1;
        #1 wr_ptr = rd_ptr;
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;
        clear_obs();
    endtask

    task automatic wait_drained(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge rclk);
            if (rd_ptr == wr_ptr) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge rclk);
            if (obs_d.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rrst_n = 1'b1; #1 rrst_n = 1'b0; #1;
        wr_ptr = rd_ptr;
        push(8'h55);
        #2;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", out_valid); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_chk++; if (out_be !== 4'h0) begin n_fail++; $display("FAIL reset_be got %h want 0", out_be); end
        n_chk++; if (words_out !== 16'h0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_out); end
        n_chk++; if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc got %b want 0", fifo_rinc); end
        @(posedge rclk); #1 rrst_n = 1'b1;
        @(negedge rclk);
        n_chk++; if (fifo_rinc !== 1'b1) begin n_fail++; $display("FAIL release_rinc got %b want 1", fifo_rinc); end
    endtask

    task automatic test_stream();
        bit ok; int gap;
        apply_reset();
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_words(2, ok);
        repeat (3) @(negedge rclk);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stream_timeout got %0d words want 2", obs_d.size()); end
        n_chk++; if (rinc_cyc.size() !== 8) begin n_fail++; $display("FAIL stream_rinc_count got %0d want 8", rinc_cyc.size()); end
        gap = (rinc_cyc.size() > 0) ? rinc_cyc[rinc_cyc.size()-1] - rinc_cyc[0] : -1;
        n_chk++; if (gap !== 7) begin n_fail++; $display("FAIL stream_rinc_span got %0d want 7", gap); end
        n_chk++; if (obs_d[0] !== 32'h04030201) begin n_fail++; $display("FAIL stream_w0 got %h want 04030201", obs_d[0]); end
        n_chk++; if (obs_b[0] !== 4'hF) begin n_fail++; $display("FAIL stream_be0 got %h want f", obs_b[0]); end
        n_chk++; if (obs_d[1] !== 32'h08070605) begin n_fail++; $display("FAIL stream_w1 got %h want 08070605", obs_d[1]); end
        n_chk++; if (obs_b[1] !== 4'hF) begin n_fail++; $display("FAIL stream_be1 got %h want f", obs_b[1]); end
        n_chk++; if (words_out !== 16'd2) begin n_fail++; $display("FAIL stream_words got %0d want 2", words_out); end
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        repeat (16) @(negedge rclk);
        n_chk++; if (rinc_cyc.size() !== 8) begin n_fail++; $display("FAIL bp_rinc_count got %0d want 8", rinc_cyc.size()); end
        n_chk++; if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL bp_hold_rinc got %b want 0", fifo_rinc); end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'h04030201) begin n_fail++; $display("FAIL bp_data got %h want 04030201", out_data); end
        repeat (3) @(negedge rclk);
        n_chk++; if (out_data !== 32'h04030201) begin n_fail++; $display("FAIL bp_stable got %h want 04030201", out_data); end
        n_chk++; if (out_be !== 4'hF) begin n_fail++; $display("FAIL bp_be got %h want f", out_be); end
        @(posedge rclk); #1 out_ready = 1'b1;
        wait_words(3, ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got %0d words want 3", obs_d.size()); end
        n_chk++; if (obs_d[0] !== 32'h04030201) begin n_fail++; $display("FAIL bp_w0 got %h want 04030201", obs_d[0]); end
        n_chk++; if (obs_d[1] !== 32'h08070605) begin n_fail++; $display("FAIL bp_w1 got %h want 08070605", obs_d[1]); end
        n_chk++; if (obs_d[2] !== 32'h0C0B0A09) begin n_fail++; $display("FAIL bp_w2 got %h want 0c0b0a09", obs_d[2]); end
    endtask

    task automatic test_flush();
        bit ok;
        apply_reset();
        push(8'hA1); push(8'hA2); push(8'hA3);
        wait_drained(ok);
        n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_drain timeout rd %0d want %0d", rd_ptr, wr_ptr); end
        @(posedge rclk); #1 flush = 1'b1;
        @(posedge rclk); #1 flush = 1'b0;
        @(negedge rclk);
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'h00A3A2A1) begin n_fail++; $display("FAIL flush_data got %h want 00a3a2a1", out_data); end
        n_chk++; if (out_be !== 4'h7) begin n_fail++; $display("FAIL flush_be got %h want 7", out_be); end
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        wait_words(2, ok);
        n_chk++; if (obs_d[1] !== 32'hB4B3B2B1) begin n_fail++; $display("FAIL flush_next got %h want b4b3b2b1", obs_d[1]); end
        n_chk++; if (obs_b[1] !== 4'hF) begin n_fail++; $display("FAIL flush_next_be got %h want f", obs_b[1]); end
    endtask

    task automatic test_flush_noop();
        bit ok;
        apply_reset();
        @(posedge rclk); #1 flush = 1'b1;
        @(posedge rclk); #1 flush = 1'b0;
        repeat (4) @(negedge rclk);
        n_chk++; if (obs_d.size() !== 0) begin n_fail++; $display("FAIL noop_empty got %0d words want 0", obs_d.size()); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL noop_valid got %b want 0", out_valid); end
        push(8'hC1); push(8'hC2); push(8'hC3);
        wait_drained(ok);
        @(posedge rclk); #1 push(8'hC4); flush = 1'b1;
        @(posedge rclk); #1 flush = 1'b0;
        repeat (4) @(negedge rclk);
        n_chk++; if (obs_d.size() !== 1) begin n_fail++; $display("FAIL noop_count got %0d want 1", obs_d.size()); end
        n_chk++; if (obs_d[0] !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL noop_word got %h want c4c3c2c1", obs_d[0]); end
        n_chk++; if (obs_b[0] !== 4'hF) begin n_fail++; $display("FAIL noop_be got %h want f", obs_b[0]); end
        n_chk++; if (words_out !== 16'd1) begin n_fail++; $display("FAIL noop_words got %0d want 1", words_out); end
    endtask

    task automatic test_flush_busy();
        bit ok;
        apply_reset();
        out_ready = 1'b0;
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5); push(8'hD6);
        wait_drained(ok);
        @(posedge rclk); #1 flush = 1'b1;
        @(posedge rclk); #1 flush = 1'b0; push(8'hD7);
        repeat (3) @(negedge rclk);
        n_chk++; if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL fbusy_rinc got %b want 0", fifo_rinc); end
        n_chk++; if (out_data !== 32'hD4D3D2D1) begin n_fail++; $display("FAIL fbusy_held got %h want d4d3d2d1", out_data); end
        @(posedge rclk); #1 out_ready = 1'b1; push(8'hD8); push(8'hD9); push(8'hDA);
        wait_words(3, ok);
        n_chk++; if (obs_d[0] !== 32'hD4D3D2D1) begin n_fail++; $display("FAIL fbusy_w0 got %h want d4d3d2d1", obs_d[0]); end
        n_chk++; if (obs_d[1] !== 32'h0000D6D5) begin n_fail++; $display("FAIL fbusy_w1 got %h want 0000d6d5", obs_d[1]); end
        n_chk++; if (obs_b[1] !== 4'h3) begin n_fail++; $display("FAIL fbusy_be1 got %h want 3", obs_b[1]); end
        n_chk++; if (obs_d[2] !== 32'hDAD9D8D7) begin n_fail++; $display("FAIL fbusy_w2 got %h want dad9d8d7", obs_d[2]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        push(8'hEE); push(8'hEF);
        wait_drained(ok);
        @(posedge rclk); #1 rrst_n = 1'b0;
        push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        for (int i = 0; i < 3; i++) begin
            @(negedge rclk);
            n_chk++; if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL rmid_rinc cycle %0d got %b want 0", i, fifo_rinc); end
        end
        @(posedge rclk); #1 rrst_n = 1'b1;
        wait_words(1, ok);
        repeat (4) @(negedge rclk);
        n_chk++; if (obs_d.size() !== 1) begin n_fail++; $display("FAIL rmid_count got %0d want 1", obs_d.size()); end
        n_chk++; if (obs_d[0] !== 32'h14131211) begin n_fail++; $display("FAIL rmid_word got %h want 14131211", obs_d[0]); end
        n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL rmid_viol got %0d want 0", viol); end
        n_chk++; if (words_out !== 16'd1) begin n_fail++; $display("FAIL rmid_words got %0d want 1", words_out); end
    endtask

    task automatic test_empty_toggle();
        apply_reset();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        empty_force = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge rclk); #1 empty_force = ~empty_force;
        end
        empty_force = 1'b0;
        repeat (2) @(negedge rclk);
        n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL tog_viol got %0d want 0", viol); end
        n_chk++; if (rinc_cyc.size() !== 4) begin n_fail++; $display("FAIL tog_rinc got %0d want 4", rinc_cyc.size()); end
        n_chk++; if (obs_d.size() !== 1) begin n_fail++; $display("FAIL tog_count got %0d want 1", obs_d.size()); end
        n_chk++; if (obs_d[0] !== 32'h04030201) begin n_fail++; $display("FAIL tog_word got %h want 04030201", obs_d[0]); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_noop();
        test_flush_busy();
        test_reset_mid();
        test_empty_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
Parameters:
REQ-001 The block SHALL have parameter DSIZE, default 8, meaning the FIFO read-data width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, meaning the number of FIFO words packed per output word (power of 2, at least 2).
Ports:
REQ-003 The block SHALL have port rclk, input, 1 bit: the single clock, the FIFO read-domain clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rrst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port fifo_rdata, input, DSIZE bits: FIFO read data, valid (fall-through) whenever fifo_rempty=0.
REQ-006 The block SHALL have port fifo_rempty, input, 1 bit: FIFO empty flag, synchronous to rclk.
REQ-007 The block SHALL have port fifo_rinc, output, 1 bit: FIFO read-increment request.
REQ-008 The block SHALL have port flush, input, 1 bit: single-cycle request to emit a partially filled word.
REQ-009 The block SHALL have port out_data, output, DSIZE*LANES bits: packed output word.
REQ-010 The block SHALL have port out_be, output, LANES bits: lane-enable mask for out_data.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data/out_be hold a word.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-013 The block SHALL have port words_out, output, 16 bits: count of words accepted downstream.

Function
REQ-014 A FIFO word SHALL be captured on a rising edge of rclk iff fifo_rinc=1 at that edge.
REQ-015 fifo_rinc SHALL equal (fifo_rempty=0) AND (state=FILL); it SHALL be combinational, with no registered lag.
REQ-016 Captured words SHALL fill lanes in little-endian order: the first word goes to bits [DSIZE-1:0], lane k to bits [DSIZE*(k+1)-1:DSIZE*k].
REQ-017 A lane counter 0..LANES-1 SHALL advance per capture and wrap to 0 when a word completes or a partial word is emitted.
REQ-018 The output slot SHALL count as free in a cycle when out_valid=0 or out_ready=1.
REQ-019 The block SHALL have exactly three states: FILL, HOLD and FLUSH.
REQ-020 In FILL, when a capture completes lane LANES-1 and the slot is free, the word SHALL load into out_data the next edge with out_be all ones and out_valid=1, and the state SHALL stay FILL (zero-bubble throughput).
REQ-021 In FILL, when a capture completes lane LANES-1 and the slot is not free, the state SHALL go to HOLD, keeping the assembled word.
REQ-022 In HOLD, fifo_rinc SHALL be 0; when the slot becomes free the assembled word SHALL transfer to the output and the state SHALL return to FILL.
REQ-023 flush SHALL be evaluated against the lane count after any same-cycle capture.
REQ-024 If that count is 0 (including a capture that just completed a full word), flush SHALL have no effect.
REQ-025 If that count is nonzero and the slot is free, the partial word SHALL load next edge, with out_be bits [count-1:0] set, the unfilled data lanes zero, and the lane counter reset to 0.
REQ-026 If that count is nonzero and the slot is not free, the state SHALL go to FLUSH (fifo_rinc=0) until the slot is free, then emit as in REQ-025 and return to FILL.
REQ-027 flush asserted in HOLD or FLUSH SHALL be ignored.
REQ-028 out_data and out_be SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 out_valid SHALL clear after acceptance unless a new word loads on the same edge.
REQ-030 words_out SHALL increment by 1 on each edge with out_valid=1 and out_ready=1, wrapping from 0xFFFF to 0.

Reset
REQ-031 While rrst_n=0, out_valid, out_data, out_be, words_out, the lane counter and the assembly register SHALL be 0, and the state SHALL be FILL, all asynchronously.
REQ-032 fifo_rinc SHALL be forced to 0 while rrst_n=0.
REQ-033 Reset mid-word SHALL discard partial data; the first capture after release SHALL go to lane 0.
REQ-034 Reset release SHALL take effect on the first rclk edge after rrst_n rises.

Verification
REQ-035 FIFO holds 0x01..0x08, out_ready=1 -> exactly 8 fifo_rinc pulses on consecutive cycles; words 0x04030201 then 0x08070605, both with out_be=0xF; words_out=2.
REQ-036 12 bytes available, out_ready=0 -> exactly 8 bytes consumed, then fifo_rinc=0 (HOLD) with out_data=0x04030201 held stable; raising out_ready -> 0x04030201, 0x08070605, 0x0C0B0A09 in order.
REQ-037 Bytes 0xA1, 0xA2, 0xA3 then flush pulse -> out_data=0x00A3A2A1 and out_be=0x7 on the next edge; the next byte lands in lane 0.
REQ-038 flush with lane count 0, and flush in the same cycle as the 4th byte -> no extra word; the full word has out_be=0xF.
REQ-039 rrst_n pulsed low after 2 bytes, then 4 bytes 0x11..0x14 -> single word 0x14131211; fifo_rinc=0 throughout reset.
REQ-040 fifo_rempty toggles every cycle while feeding 0x01..0x04 -> fifo_rinc never asserted while empty; output word 0x04030201.
